clint_regfile: RTL

//  Memory-mapped CLINT register file: holds mtime, mtimecmp and msip, and drives count/countcmp/msip

---
 rtl/clint_regfile.sv | 139 +++++++++++++
 1 files changed

// File: rtl/clint_regfile.sv
// rtl/clint_regfile.sv - CLINT mtime/mtimecmp/msip register file with valid/ready bus slave
// Optional feature macro: CLINT_TIME_STOP_EN (adds dbg_halt, freezes mtime advance while halted)
module clint_regfile #(
    parameter int unsigned      ADDR_W       = 16,
    parameter logic [15:0]      MSIP_OFS     = 16'h0000,
    parameter logic [15:0]      MTIMECMP_OFS = 16'h4000,
    parameter logic [15:0]      MTIME_OFS    = 16'hBFF8,
    parameter logic [63:0]      CMP_RST      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    input  logic              trigger_edge,
    output logic [63:0]       count,
    output logic [63:0]       countcmp,
`ifdef CLINT_TIME_STOP_EN
    output logic [63:0]       msip,
    input  logic              dbg_halt
`else
    output logic [63:0]       msip
`endif
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state_q, state_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        accept;
    logic        wr;
    logic        hit_msip, hit_cmp, hit_time, hit_any;
    logic        tick;
    logic [63:0] rd_val;

    function automatic logic [63:0] merge(input logic [63:0] old_v,
                                          input logic [63:0] new_v,
                                          input logic [7:0]  strb);
        logic [63:0] r;
        r = old_v;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        accept   = req_valid && (state_q == IDLE);
        wr       = accept && req_we;
        hit_msip = (req_addr[ADDR_W-1:3] == MSIP_OFS[ADDR_W-1:3]);
        hit_cmp  = (req_addr[ADDR_W-1:3] == MTIMECMP_OFS[ADDR_W-1:3]);
        hit_time = (req_addr[ADDR_W-1:3] == MTIME_OFS[ADDR_W-1:3]);
        hit_any  = hit_msip || hit_cmp || hit_time;
`ifdef CLINT_TIME_STOP_EN
        tick     = trigger_edge && !dbg_halt;
`else
        tick     = trigger_edge;
`endif

        rd_val = 64'd0;
        if (hit_msip)      rd_val = {63'd0, msip_q};
        else if (hit_cmp)  rd_val = mtimecmp_q;
        else if (hit_time) rd_val = mtime_q;

        // A bus write to mtime replaces that cycle's increment entirely.
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr && hit_time) mtime_d = merge(mtime_q, req_wdata, req_wstrb);

        mtimecmp_d = mtimecmp_q;
        if (wr && hit_cmp) mtimecmp_d = merge(mtimecmp_q, req_wdata, req_wstrb);

        msip_d = msip_q;
        if (wr && hit_msip && req_wstrb[0]) msip_d = req_wdata[0];

        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = req_we ? 64'd0 : rd_val;
                    rsp_err_d   = !hit_any;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= CMP_RST;
            msip_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign count     = mtime_q;
    assign countcmp  = mtimecmp_q;
    assign msip      = {63'd0, msip_q};

endmodule
